// File: rtl/ws2811_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ws2811_frame_receiver_if
// Description : Bundle of the decoded bit stream from the ws2811 decoder, the
//               captured-frame outputs and the daisy-chain forwarding outputs.
//               master = decoder/stimulus side, slave = frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface ws2811_frame_receiver_if #(
    parameter int DATA_BITS = 32
) ();
    // Decoder stream
    logic                 dataIn;
    logic                 dataClk;
    logic                 active;
    // Captured frame
    logic [DATA_BITS-1:0] rxData;
    logic                 rxValid;
    logic                 rxErr;
    // Daisy-chain forwarding
    logic                 fwdBit;
    logic                 fwdStrobe;
    logic                 fwdActive;
    // Session bit counter
    logic [15:0]          bitCnt;

    modport master (
        output dataIn, dataClk, active,
        input  rxData, rxValid, rxErr, fwdBit, fwdStrobe, fwdActive, bitCnt
    );

    modport slave (
        input  dataIn, dataClk, active,
        output rxData, rxValid, rxErr, fwdBit, fwdStrobe, fwdActive, bitCnt
    );
endinterface
`default_nettype wire

// File: rtl/ws2811_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ws2811_frame_receiver
// Description : Captures the first DATA_BITS bits of each decoder session
//               MSB-first into rxData (rxValid/rxErr at session close) and
//               forwards every later bit on fwdBit/fwdStrobe.
//               Optional feature macro RX_CRC8_EN: the last 8 captured bits
//               are a CRC-8 (poly 0x07, init 0) over the preceding bits.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2811_frame_receiver #(
    parameter int DATA_BITS = 32
) (
    input  wire                     masterClk,
    input  wire                     reset,
    ws2811_frame_receiver_if.slave  bus
);

    localparam logic [15:0] c_FRAME_BITS = 16'(DATA_BITS);
    localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SKIP    = 3'd1,
        S_CAPTURE = 3'd2,
        S_FORWARD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic                 r_dataClkPrev;
    logic                 r_activePrev;
    logic [DATA_BITS-1:0] r_shift;
    logic [15:0]          r_bitCnt;
    logic [DATA_BITS-1:0] r_rxData;
    logic                 r_rxValid;
    logic                 r_rxErr;
    logic                 r_fwdBit;
    logic                 r_fwdStrobe;
    logic                 r_fwdActive;

    logic                 w_rise;
    logic                 w_close;
    logic                 w_accept;
    logic                 w_clear;
    logic                 w_capBit;
    logic                 w_fwdBit;
    logic                 w_enterDone;
    logic                 w_frameGood;
    logic                 w_crcOk;
    logic [15:0]          w_cntInc;
    logic [15:0]          w_cntNext;
    logic [DATA_BITS-1:0] w_shiftNext;

    assign w_rise   = bus.dataClk & ~r_dataClkPrev;
    assign w_close  = ~bus.active & r_activePrev;
    assign w_cntInc = (r_bitCnt == c_CNT_MAX) ? r_bitCnt : r_bitCnt + 16'd1;

    // Next-state decode: which state follows and whether this rise carries a bit
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A rise in the session-start cycle is the discarded skip edge
                if (bus.active) begin
                    w_clear     = 1'b1;
                    w_nextState = w_rise ? S_CAPTURE : S_SKIP;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_SKIP: begin
                if (w_close)
                    w_nextState = S_DONE;
                else if (w_rise)
                    w_nextState = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_accept = w_rise;
                // Close wins over the FORWARD hand-off; the bit still counts
                if (w_close)
                    w_nextState = S_DONE;
                else if (w_rise && (w_cntInc == c_FRAME_BITS))
                    w_nextState = S_FORWARD;
            end
            S_FORWARD: begin
                w_accept = w_rise;
                if (w_close)
                    w_nextState = S_DONE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath next values; the frame is judged on these so a bit arriving with the close is included
    always_comb begin
        w_capBit    = w_accept && (r_state == S_CAPTURE);
        w_fwdBit    = w_accept && (r_state == S_FORWARD);
        w_enterDone = (w_nextState == S_DONE);
        w_cntNext   = w_clear ? 16'd0 : (w_accept ? w_cntInc : r_bitCnt);
        if (w_clear)
            w_shiftNext = '0;
        else if (w_capBit)
            w_shiftNext = {r_shift[DATA_BITS-2:0], bus.dataIn};
        else
            w_shiftNext = r_shift;
        w_frameGood = (w_cntNext >= c_FRAME_BITS) && w_crcOk;
    end

`ifdef RX_CRC8_EN
    localparam logic [15:0] c_PAYLOAD_BITS = 16'(DATA_BITS - 8);

    logic [7:0] r_crc;
    logic [7:0] w_crcNext;
    logic       w_crcFb;

    // Serial CRC-8 over the payload bits only; the trailing 8 bits are the check value
    always_comb begin
        w_crcFb = r_crc[7] ^ bus.dataIn;
        if (w_clear)
            w_crcNext = 8'h00;
        else if (w_capBit && (r_bitCnt < c_PAYLOAD_BITS))
            w_crcNext = {r_crc[6:0], 1'b0} ^ (w_crcFb ? 8'h07 : 8'h00);
        else
            w_crcNext = r_crc;
        w_crcOk = (w_shiftNext[7:0] == w_crcNext);
    end

    // CRC accumulator register
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset)
            r_crc <= 8'h00;
        else
            r_crc <= w_crcNext;
    end
`else
    assign w_crcOk = 1'b1;
`endif

    // State register
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    // Edge-detect history, capture/count registers and registered outputs
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            r_dataClkPrev <= 1'b0;
            r_activePrev  <= 1'b0;
            r_shift       <= '0;
            r_bitCnt      <= 16'd0;
            r_rxData      <= '0;
            r_rxValid     <= 1'b0;
            r_rxErr       <= 1'b0;
            r_fwdBit      <= 1'b0;
            r_fwdStrobe   <= 1'b0;
            r_fwdActive   <= 1'b0;
        end else begin
            r_dataClkPrev <= bus.dataClk;
            r_activePrev  <= bus.active;
            r_shift       <= w_shiftNext;
            r_bitCnt      <= w_cntNext;
            r_rxValid     <= w_enterDone && w_frameGood;
            r_rxErr       <= w_enterDone && !w_frameGood;
            r_fwdStrobe   <= w_fwdBit;
            if (w_enterDone && w_frameGood)
                r_rxData <= w_shiftNext;
            if (w_fwdBit)
                r_fwdBit <= bus.dataIn;
            if (w_enterDone)
                r_fwdActive <= 1'b0;
            else if (w_fwdBit)
                r_fwdActive <= 1'b1;
        end
    end

    assign bus.rxData    = r_rxData;
    assign bus.rxValid   = r_rxValid;
    assign bus.rxErr     = r_rxErr;
    assign bus.fwdBit    = r_fwdBit;
    assign bus.fwdStrobe = r_fwdStrobe;
    assign bus.fwdActive = r_fwdActive;
    assign bus.bitCnt    = r_bitCnt;

endmodule
`default_nettype wire

// File: tb/tb_ws2811_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2811_frame_receiver
// Description : Directed self-checking bench for ws2811_frame_receiver
//               (DATA_BITS = 32). Frame values switch to CRC-valid ones when
//               RX_CRC8_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2811_frame_receiver;

`ifdef RX_CRC8_EN
    localparam logic [31:0] c_F1 = 32'h0000_0107;
    localparam logic [31:0] c_F2 = 32'h0000_020E;
    localparam logic [31:0] c_F4 = 32'h0000_0309;
    localparam int          c_EXP_ERR = 2;
`else
    localparam logic [31:0] c_F1 = 32'hA5C3_0F81;
    localparam logic [31:0] c_F2 = 32'h1234_5678;
    localparam logic [31:0] c_F4 = 32'hCAFE_BABE;
    localparam int          c_EXP_ERR = 1;
`endif

    logic masterClk = 1'b0;
    logic reset     = 1'b1;

    int errors = 0;
    int checks = 0;

    int       nValid = 0;
    int       nErr = 0;
    int       nStrobe = 0;
    int       nBoth = 0;
    int       nFwdInactive = 0;
    logic [7:0] fwdSeq = 8'h00;

    ws2811_frame_receiver_if #(.DATA_BITS(32)) bus ();

    ws2811_frame_receiver #(.DATA_BITS(32)) dut (
        .masterClk (masterClk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 masterClk = ~masterClk;

    // Pulse monitor sampled on the falling edge
    always @(negedge masterClk) begin
        if (!reset) begin
            if (bus.rxValid) nValid <= nValid + 1;
            if (bus.rxErr) nErr <= nErr + 1;
            if (bus.rxValid && bus.rxErr) nBoth <= nBoth + 1;
            if (bus.fwdStrobe) begin
                nStrobe <= nStrobe + 1;
                fwdSeq  <= {fwdSeq[6:0], bus.fwdBit};
                if (!bus.fwdActive) nFwdInactive <= nFwdInactive + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        bus.dataIn  = b;
        bus.dataClk = 1'b1;
        tick();
        bus.dataClk = 1'b0;
        tick();
    endtask

    task automatic sendBits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic startSession();
        bus.active = 1'b1;
        tick();
        sendBit(1'b1);      // skip edge, carries no data
    endtask

    task automatic closeSession();
        bus.active = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [31:0] f4;

    initial begin
        bus.dataIn  = 1'b0;
        bus.dataClk = 1'b0;
        bus.active  = 1'b0;
        f4          = c_F4;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset state
        check("rst_rxData",    64'(bus.rxData), 64'h0);
        check("rst_rxValid",   64'(bus.rxValid), 64'h0);
        check("rst_rxErr",     64'(bus.rxErr), 64'h0);
        check("rst_fwdBit",    64'(bus.fwdBit), 64'h0);
        check("rst_fwdStrobe", 64'(bus.fwdStrobe), 64'h0);
        check("rst_fwdActive", 64'(bus.fwdActive), 64'h0);
        check("rst_bitCnt",    64'(bus.bitCnt), 64'h0);

        // Exact-length frame
        startSession();
        sendBits(64'(c_F1), 32);
        check("f1_preclose_valid", 64'(bus.rxValid), 64'h0);
        closeSession();
        check("f1_rxValid",    64'(bus.rxValid), 64'h1);
        check("f1_rxErr",      64'(bus.rxErr), 64'h0);
        check("f1_rxData",     64'(bus.rxData), 64'(c_F1));
        check("f1_bitCnt",     64'(bus.bitCnt), 64'd32);
        tick();
        check("f1_valid_1cyc", 64'(bus.rxValid), 64'h0);
        idle(3);
        check("f1_nValid",     64'(nValid), 64'd1);
        check("f1_nStrobe",    64'(nStrobe), 64'd0);

        // 40-bit frame: last 8 bits forwarded
        startSession();
        sendBits(64'(c_F2), 32);
        check("f2_fwdActive_before", 64'(bus.fwdActive), 64'h0);
        check("f2_bitCnt32",         64'(bus.bitCnt), 64'd32);
        sendBits(64'hB2, 8);
        check("f2_fwdActive_during", 64'(bus.fwdActive), 64'h1);
        check("f2_bitCnt40",         64'(bus.bitCnt), 64'd40);
        check("f2_fwdBit_last",      64'(bus.fwdBit), 64'h0);
        closeSession();
        check("f2_rxValid",    64'(bus.rxValid), 64'h1);
        check("f2_rxData",     64'(bus.rxData), 64'(c_F2));
        check("f2_fwdActive_done", 64'(bus.fwdActive), 64'h0);
        idle(3);
        check("f2_nStrobe",    64'(nStrobe), 64'd8);
        check("f2_fwdSeq",     64'(fwdSeq), 64'hB2);
        check("f2_fwdInactive", 64'(nFwdInactive), 64'd0);

        // Short frame rejected
        startSession();
        sendBits(64'h000F_FFFF, 20);
        closeSession();
        check("short_rxErr",   64'(bus.rxErr), 64'h1);
        check("short_rxValid", 64'(bus.rxValid), 64'h0);
        check("short_rxData",  64'(bus.rxData), 64'(c_F2));
        check("short_bitCnt",  64'(bus.bitCnt), 64'd20);
        tick();
        check("short_err_1cyc", 64'(bus.rxErr), 64'h0);
        idle(2);

`ifdef RX_CRC8_EN
        // CRC mismatch rejected
        startSession();
        sendBits(64'h0000_0106, 32);
        closeSession();
        check("crc_bad_rxErr",  64'(bus.rxErr), 64'h1);
        check("crc_bad_rxData", 64'(bus.rxData), 64'(c_F2));
        idle(3);
`endif

        // Final bit rise coincides with session close
        startSession();
        sendBits(64'(f4 >> 1), 31);
        bus.dataIn  = f4[0];
        bus.dataClk = 1'b1;
        bus.active  = 1'b0;
        tick();
        bus.dataClk = 1'b0;
        check("sim_rxValid", 64'(bus.rxValid), 64'h1);
        check("sim_rxData",  64'(bus.rxData), 64'(c_F4));
        check("sim_bitCnt",  64'(bus.bitCnt), 64'd32);
        idle(3);

        // Reset mid-session with active held high
        startSession();
        sendBits(64'h3FF, 10);
        check("mid_bitCnt10", 64'(bus.bitCnt), 64'd10);
        reset = 1'b1;
        #1;
        check("mid_rst_rxData", 64'(bus.rxData), 64'h0);
        check("mid_rst_bitCnt", 64'(bus.bitCnt), 64'h0);
        check("mid_rst_flags",  64'({bus.rxValid, bus.rxErr, bus.fwdBit, bus.fwdStrobe, bus.fwdActive}), 64'h0);
        idle(2);
        reset = 1'b0;
        tick();
        sendBit(1'b1);      // skip edge of the fresh session
        sendBits(64'(c_F1), 32);
        closeSession();
        check("mid_rxValid", 64'(bus.rxValid), 64'h1);
        check("mid_rxData",  64'(bus.rxData), 64'(c_F1));
        check("mid_bitCnt",  64'(bus.bitCnt), 64'd32);
        idle(4);

        check("tot_nValid", 64'(nValid), 64'd4);
        check("tot_nErr",   64'(nErr), 64'(c_EXP_ERR));
        check("tot_nBoth",  64'(nBoth), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
